mem_ram_arbiter: RTL and testbench

//  Shares the single-port 32x8 mem_RAM between two requesters: A (CPU data port) and B (loader/DMA).

---
 rtl/mem_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B, with zero-fill after reset.
// Latency: grant one edge after REQ is sampled in IDLE; write lands one edge later; read data two edges after grant.
// Backpressure: REQ is held until GNT; REQs are not sampled during CLEAR, ACCESS or RDCAP and wait without loss.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   a_req_i/a_we_i/a_addr_i/a_d_i  requester A command (held stable until a_gnt_o)
//   a_gnt_o, a_valid_o           A command accepted / rdata_o holds A read result (1-cycle pulses)
//   b_*                          identical set for requester B
//   rdata_o                      last read result, held until the next read completes
//   busy_o                       high while the post-reset zero-fill runs
//   ram_d_o/ram_addr_o/ram_we_o  RAM pins; ram_q_i is RAM read data, valid the cycle after the address
module mem_ram_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_d_i,
    output logic              a_gnt_o,
    output logic              a_valid_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_d_i,
    output logic              b_gnt_o,
    output logic              b_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] ram_d_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_q_i
);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_ACCESS, ST_RDCAP} state_t;

    localparam state_t      RST_STATE = (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic        RST_BUSY  = (CLEAR_EN != 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                owner_b_q, owner_b_d;   // requester currently in service
    logic                prio_b_q, prio_b_d;     // B wins the next tie
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_d_q, ram_d_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic                a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic                busy_q, busy_d;
    logic                pick_b;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            owner_b_q  <= 1'b0;
            prio_b_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_d_q    <= '0;
            rdata_q    <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            busy_q     <= RST_BUSY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_b_q  <= owner_b_d;
            prio_b_q   <= prio_b_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_d_q    <= ram_d_d;
            rdata_q    <= rdata_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_b_d  = owner_b_q;
        prio_b_d   = prio_b_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_d_d    = ram_d_q;
        rdata_d    = rdata_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_valid_d  = 1'b0;
        b_valid_d  = 1'b0;
        busy_d     = busy_q;
        pick_b     = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                ram_we_d   = 1'b1;
                ram_d_d    = '0;
                ram_addr_d = cnt_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                ram_we_d = 1'b0;
                if (a_req_i || b_req_i) begin
                    // A lone requester always wins; on a tie the pointer decides.
                    pick_b     = b_req_i && (!a_req_i || prio_b_q);
                    owner_b_d  = pick_b;
                    ram_we_d   = pick_b ? b_we_i   : a_we_i;
                    ram_addr_d = pick_b ? b_addr_i : a_addr_i;
                    ram_d_d    = pick_b ? b_d_i    : a_d_i;
                    a_gnt_d    = !pick_b;
                    b_gnt_d    = pick_b;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // ram_we_q still carries the command type of the access in flight.
                ram_we_d = 1'b0;
                prio_b_d = !owner_b_q;
                state_d  = ram_we_q ? ST_IDLE : ST_RDCAP;
            end
            ST_RDCAP: begin
                rdata_d   = ram_q_i;
                a_valid_d = !owner_b_q;
                b_valid_d = owner_b_q;
                state_d   = ST_IDLE;
            end
            default: state_d = RST_STATE;
        endcase
    end

    assign a_gnt_o    = a_gnt_q;
    assign b_gnt_o    = b_gnt_q;
    assign a_valid_o  = a_valid_q;
    assign b_valid_o  = b_valid_q;
    assign rdata_o    = rdata_q;
    assign busy_o     = busy_q;
    assign ram_d_o    = ram_d_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_we_o   = ram_we_q;

endmodule

// File: tb/tb_mem_ram_arbiter.sv
// Testbench for mem_ram_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Latency: checks every cycle one edge after the clock; model predicts grant/valid cycles from service times.
// Backpressure: requesters hold REQ until GNT is seen and drop it the following edge.
module tb_mem_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rq  [2];
    logic       rwe [2];
    logic [4:0] rad [2];
    logic [7:0] rdd [2];

    logic       a_gnt, a_vld, b_gnt, b_vld, busy, ram_we;
    logic [7:0] rdata, ram_d, ram_q;
    logic [4:0] ram_addr;

    // Second instance built without zero-fill.
    logic       c_req, c_gnt, c_vld, c_bgnt, c_bvld, c_busy, c_ram_we;
    logic [7:0] c_rdata, c_ram_d;
    logic [4:0] c_ram_addr;

    mem_ram_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(rq[0]), .a_we_i(rwe[0]), .a_addr_i(rad[0]), .a_d_i(rdd[0]),
        .a_gnt_o(a_gnt), .a_valid_o(a_vld),
        .b_req_i(rq[1]), .b_we_i(rwe[1]), .b_addr_i(rad[1]), .b_d_i(rdd[1]),
        .b_gnt_o(b_gnt), .b_valid_o(b_vld),
        .rdata_o(rdata), .busy_o(busy),
        .ram_d_o(ram_d), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_q_i(ram_q)
    );

    mem_ram_arbiter #(.CLEAR_EN(0)) dut_nc (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(c_req), .a_we_i(rwe[0]), .a_addr_i(rad[0]), .a_d_i(rdd[0]),
        .a_gnt_o(c_gnt), .a_valid_o(c_vld),
        .b_req_i(1'b0), .b_we_i(1'b0), .b_addr_i(5'd0), .b_d_i(8'd0),
        .b_gnt_o(c_bgnt), .b_valid_o(c_bvld),
        .rdata_o(c_rdata), .busy_o(c_busy),
        .ram_d_o(c_ram_d), .ram_addr_o(c_ram_addr), .ram_we_o(c_ram_we), .ram_q_i(8'd0)
    );

    // Single-port synchronous RAM; preload port lets the bench fill it with nonzero junk.
    logic [7:0] mem [32];
    logic       pre_we;
    logic [4:0] pre_a;
    logic [7:0] pre_d;
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    int tests = 0;
    int fails = 0;

    // Transaction-level model state
    int         t, rst_t, free_t, vld_t;
    bit         last_a, vld_b;
    logic [7:0] vld_dat, exp_rdata;
    logic [7:0] ref_mem [32];
    int         left [2];
    bit         cont [2], rnd [2];
    logic       fwe [2];
    logic [4:0] fad [2];
    logic [7:0] fdd [2];
    int         last_gnt_t [2];
    int         order [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic gen(input int i);
        if (rnd[i]) begin
            rwe[i] = 1'($urandom % 2);
            rad[i] = 5'($urandom % 32);
            rdd[i] = 8'($urandom);
        end else begin
            rwe[i] = fwe[i];
            rad[i] = fad[i];
            rdd[i] = fdd[i];
        end
    endtask

    // Advance one edge, predict what the arbiter must show, compare, then update requesters.
    task automatic step();
        logic       sr [2];
        logic       swe [2];
        logic [4:0] sad [2];
        logic [7:0] sdd [2];
        logic       rs, ga, gb, ewe, clr;
        int         ow;
        for (int i = 0; i < 2; i++) begin
            sr[i] = rq[i]; swe[i] = rwe[i]; sad[i] = rad[i]; sdd[i] = rdd[i];
        end
        rs = rst;
        @(posedge clk);
        #1;
        t++;
        ga = 1'b0; gb = 1'b0; ow = 0; ewe = 1'b0;
        if (rs) begin
            rst_t = t; free_t = t + 33; last_a = 1'b0; vld_t = -1; exp_rdata = 8'h00;
            for (int k = 0; k < 32; k++) ref_mem[k] = 8'h00;
        end else if (t >= free_t && (sr[0] || sr[1])) begin
            ow = (sr[0] && sr[1]) ? (last_a ? 1 : 0) : (sr[0] ? 0 : 1);
            ga = (ow == 0); gb = (ow == 1); last_a = (ow == 0);
            if (swe[ow]) begin
                ref_mem[sad[ow]] = sdd[ow];
                free_t = t + 2;
                ewe = 1'b1;
            end else begin
                vld_t = t + 2; vld_b = (ow == 1); vld_dat = ref_mem[sad[ow]];
                free_t = t + 3;
            end
            order.push_back(ow);
            last_gnt_t[ow] = t;
        end
        clr = !rs && t > rst_t && t <= rst_t + 32;
        if (clr) ewe = 1'b1;
        if (vld_t == t) exp_rdata = vld_dat;
        chk("a_gnt", a_gnt, ga);
        chk("b_gnt", b_gnt, gb);
        chk("a_valid", a_vld, (vld_t == t) && !vld_b);
        chk("b_valid", b_vld, (vld_t == t) && vld_b);
        chk("rdata", rdata, exp_rdata);
        chk("busy", busy, rs || (t > rst_t && t <= rst_t + 31));
        chk("ram_we", ram_we, ewe);
        if (rs) begin
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_d", ram_d, 0);
        end else if (clr) begin
            chk("clr_addr", ram_addr, 32'(t - rst_t - 1));
            chk("clr_d", ram_d, 0);
        end else if (ga || gb) begin
            chk("cmd_addr", ram_addr, sad[ow]);
            chk("cmd_d", ram_d, sdd[ow]);
        end
        for (int i = 0; i < 2; i++) begin
            if ((i == 0) ? a_gnt : b_gnt) rq[i] = 1'b0;
            if (!rq[i] && left[i] > 0 && (cont[i] || ($urandom % 2) == 1)) begin
                gen(i);
                rq[i] = 1'b1;
                left[i]--;
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((rq[0] || rq[1] || left[0] > 0 || left[1] > 0 || t < free_t) && n < bound) begin
            step();
            n++;
        end
        chk("drain_timeout", (n >= bound), 0);
    endtask

    task automatic issue(input int i, input logic we, input logic [4:0] ad, input logic [7:0] d);
        fwe[i] = we; fad[i] = ad; fdd[i] = d;
        rnd[i] = 1'b0; cont[i] = 1'b1; left[i] = 1;
        drain(50);
    endtask

    initial begin
        int n;
        rst = 1'b1; c_req = 1'b0; pre_we = 1'b1; pre_a = '0; pre_d = '0;
        t = 0; rst_t = -100; free_t = 0; vld_t = -1; last_a = 1'b0; vld_b = 1'b0;
        vld_dat = '0; exp_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; rwe[i] = 1'b0; rad[i] = '0; rdd[i] = '0;
            left[i] = 0; cont[i] = 1'b0; rnd[i] = 1'b0; last_gnt_t[i] = -1;
            fwe[i] = 1'b0; fad[i] = '0; fdd[i] = '0;
        end
        for (int k = 0; k < 32; k++) ref_mem[k] = 8'h00;

        // Reset while preloading the RAM with nonzero contents
        for (int k = 0; k < 32; k++) begin
            pre_a = 5'(k);
            pre_d = 8'(k) | 8'h80;
            step();
        end
        pre_we = 1'b0;
        chk("nc_busy_rst", c_busy, 0);

        // B read of addr 15 raised during zero-fill; no-clear instance requested on release
        fwe[1] = 1'b0; fad[1] = 5'd15; fdd[1] = 8'h00;
        rnd[1] = 1'b0; cont[1] = 1'b1; left[1] = 1;
        c_req = 1'b1;
        rst = 1'b0;
        step();
        chk("nc_gnt_first_edge", c_gnt, 1);
        chk("nc_busy", c_busy, 0);
        c_req = 1'b0;
        n = 0;
        while (!b_gnt && n < 60) begin
            step();
            n++;
        end
        chk("b_gnt_after_clear", 32'(last_gnt_t[1] - rst_t), 33);
        drain(50);
        chk("zero_rd15", rdata, 8'h00);
        issue(0, 1'b0, 5'd0, 8'h00);
        chk("zero_rd0", rdata, 8'h00);
        issue(0, 1'b0, 5'd31, 8'h00);
        chk("zero_rd31", rdata, 8'h00);
        issue(1, 1'b0, 5'd2, 8'h00);     // B served last, so A wins the next tie

        // Both requesters held: four writes each, must alternate starting with A
        order.delete();
        fwe[0] = 1'b1; fad[0] = 5'd1; fdd[0] = 8'h11; rnd[0] = 1'b0; cont[0] = 1'b1; left[0] = 4;
        fwe[1] = 1'b1; fad[1] = 5'd2; fdd[1] = 8'h22; rnd[1] = 1'b0; cont[1] = 1'b1; left[1] = 4;
        drain(100);
        chk("tie_count", order.size(), 8);
        for (int k = 0; k < order.size(); k++) chk("tie_order", 32'(order[k]), 32'(k % 2));
        issue(0, 1'b0, 5'd1, 8'h00);
        chk("tie_mem1", rdata, 8'h11);
        issue(1, 1'b0, 5'd2, 8'h00);
        chk("tie_mem2", rdata, 8'h22);

        // Random traffic from both sides
        for (int i = 0; i < 2; i++) begin
            rnd[i] = 1'b1; cont[i] = 1'b0; left[i] = 40;
        end
        drain(3000);

        // A write then read of addr 5
        issue(0, 1'b1, 5'd5, 8'hA5);
        issue(0, 1'b0, 5'd5, 8'h00);
        chk("a_rd5", rdata, 8'hA5);

        // Reset while the A read sits in RDCAP
        fwe[0] = 1'b0; fad[0] = 5'd5; fdd[0] = 8'h00; rnd[0] = 1'b0; cont[0] = 1'b1; left[0] = 1;
        n = 0;
        while (!a_gnt && n < 20) begin
            step();
            n++;
        end
        chk("rdcap_gnt", a_gnt, 1);
        step();
        rst = 1'b1;
        step();
        chk("rdcap_rst_valid", a_vld, 0);
        chk("rdcap_rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        step();
        chk("refill_addr0", ram_addr, 0);
        drain(60);
        issue(0, 1'b0, 5'd5, 8'h00);
        chk("refill_rd5", rdata, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
